alu_shift_seq: RTL and testbench
================================

# alu_shift_seq

Registered, sequencing ALU controller for the mMips execute stage, replacing the combinational ALU control decode. It decodes ALUop/functionCode into the 6-bit ALU control code. It also supports arbitrary shift amounts by decomposing SLL/SRL/SRA into a multi-cycle sequence of the ALU's fixed 8-, 2- and 1-bit shift passes. While a sequence runs, it stalls the pipeline and tells the datapath to feed the ALU result back as operand.

## Interface
- SHAMT_W, 5: width of shift-amount input and remaining-shift counter (5 for 32-bit, 6 for 64-bit datapath).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decode request this cycle.
- in_ready  out  1  request accepted this cycle; high when no shift steps remain pending.
- flush  in  1  synchronous abort of pending sequence.
- functionCode  in  6  R-type funct field.
- ALUop  in  5  main-decoder ALU operation.
- Shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  ALUctrl valid this cycle.
- ALUctrl  out  6  ALU control code.
- out_first  out  1  step takes operand from register file; 0 means operand is previous ALU result.
- out_last  out  1  final step of the operation; the writeback may commit.

## Operation
- ALUop decode: 0→0x02, 1→0x06, 3→0x03, 4→0x00, 5→0x01, 6→0x04, 7→0x07, 8→0x08, 9→0x09, other (≠2)→0x00.
- ALUop 2 (R-type) decodes by funct:
  - 0x10/0x12→0x00, 0x19→0x13, 0x20→0x02, 0x21→0x03, 0x23→0x06.
  - 0x24→0x00, 0x25→0x01, 0x26→0x04, 0x2A→0x07, 0x2B→0x08.
  - Other→0x00.
- Shift (ALUop 2, funct 0x00 SLL / 0x02 SRL / 0x03 SRA) uses step codes:
  - SLL: 8→0x0C, 2→0x0B, 1→0x0A.
  - SRL: 8→0x0F, 2→0x0E, 1→0x0D.
  - SRA: 8→0x12, 2→0x11, 1→0x10.
- Greedy decomposition on remaining count rem, one step per cycle: rem≥8 → 8-step; else rem≥2 → 2-step; else 1-step. rem decrements by the step taken.
- Step count = ⌊S/8⌋ + ⌊(S mod 8)/2⌋ + (S mod 2). Shamt 31 gives 7 steps.
- Shamt 0 shift: single step, ALUctrl 0x00, out_first=out_last=1.
- Non-shift ops: single step, out_first=out_last=1.
- States:
  - IDLE (rem=0): in_ready=1.
  - SEQ (rem>0): in_ready=0, kind and rem held. Moves to IDLE when the step emitted drives rem to 0.
- Accepted request: latch kind and Shamt. The first step computes from Shamt directly.
- in_ready is combinational from rem==0. Back-to-back requests are accepted in the cycle the last step is emitted.

## Timing
- Latency: request accepted at edge N; first step visible (out_valid=1) during cycle N+1. Step k is visible during cycle N+k.
- n-step operation: out_valid high n consecutive cycles. out_first only on step 1, out_last only on step n. in_ready low on steps 1..n-1.
- No request accepted: out_valid=0, ALUctrl=0x00, out_first=out_last=0 next cycle.
- Reset (any time, incl. mid-sequence): out_valid=0, ALUctrl=0x00, out_first=0, out_last=0, rem=0, state IDLE. in_ready=1 immediately; sequence discarded.
- flush: next cycle out_valid=0, rem=0, IDLE.
- flush and in_valid in the same cycle: flush wins, request dropped.
- flush with rem=0: only suppresses the new request.
- in_valid while in_ready=0: ignored, no queuing. Upstream must hold the request.

## Configuration
- ALUSEQ_CUSTOM_EN defined: funct 0x30 (clip)→ALUctrl 0x30, funct 0x34→ALUctrl 0x34, each single step.
- Undefined: both functs decode to 0x00, as with any unknown funct.

## Test plan
- SLL Shamt 11 → ALUctrl 0x0C, 0x0B, 0x0A on cycles N+1..N+3. out_first only at N+1, out_last only at N+3, in_ready low at N+1..N+2.
- SRA Shamt 31 → seven steps 0x12,0x12,0x12,0x11,0x11,0x11,0x10. New ADD (ALUop 2, funct 0x20) presented on step 7 is accepted; 0x02 appears next cycle with out_first=out_last=1.
- ALUop 9 → single 0x09. ALUop 2/funct 0x19 → 0x13. ALUop 2/funct 0x00/Shamt 0 → 0x00 single step.
- SRL Shamt 9, rst low during step 1 → all outputs 0 and in_ready=1 immediately. Release rst → out_valid stays 0 until next request.
- SLL Shamt 5, flush on step 1 together with in_valid → step 2 never emitted, request dropped, out_valid=0 next cycle.
- ALUop 2/funct 0x30 → 0x30 with ALUSEQ_CUSTOM_EN, 0x00 without.

Source files
------------

// File: rtl/alu_shift_seq_if.sv
// alu_shift_seq_if
// Groups the decode request and the ALU-control result of alu_shift_seq
// into one bundle.
//
// Handshake: a request transfers on a rising clk edge when in_valid and
// in_ready are both high and flush is low. in_ready depends only on
// controller state and never on in_valid. A request seen while in_ready is
// low is not stored, so the requester must hold it until it is accepted.
// The out_* signals are a registered stream with no back-pressure.
//
// Signals
//   in_valid     request present
//   in_ready     controller can take a request this cycle
//   flush        synchronous abort of any pending shift sequence
//   functionCode R-type funct field
//   ALUop        main-decoder ALU operation
//   Shamt        shift amount
//   out_valid    ALUctrl holds a valid step
//   ALUctrl      6-bit ALU control code
//   out_first    step reads its operand from the register file
//   out_last     final step; writeback may commit
//
// Modports: slave is the controller, master is the pipeline side.
interface alu_shift_seq_if #(
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [5:0]         functionCode;
  logic [4:0]         ALUop;
  logic [SHAMT_W-1:0] Shamt;
  logic               out_valid;
  logic [5:0]         ALUctrl;
  logic               out_first;
  logic               out_last;

  modport slave (
    input  in_valid, flush, functionCode, ALUop, Shamt,
    output in_ready, out_valid, ALUctrl, out_first, out_last
  );

  modport master (
    output in_valid, flush, functionCode, ALUop, Shamt,
    input  in_ready, out_valid, ALUctrl, out_first, out_last
  );
endinterface

// File: rtl/alu_shift_seq.sv
// alu_shift_seq
// Registered ALU control decode for the mMips execute stage. Shifts of an
// arbitrary amount are split into a sequence of the ALU's fixed 8-, 2- and
// 1-bit shift passes, one pass per cycle. Every pass after the first takes
// the previous ALU result as its operand (out_first low). The pipeline is
// stalled through in_ready while passes are still pending.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   bus          alu_shift_seq_if.slave (request in, ALU control out)
//   dbg_state_o  current state: IDLE (0) or SEQ (1)
//
// Build option: define ALUSEQ_CUSTOM_EN to decode funct 0x30 and 0x34 into
// ALUctrl 0x30 and 0x34. Without it both decode to 0x00.
module alu_shift_seq #(
  parameter int SHAMT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_shift_seq_if.slave       bus,
  output logic [0:0]           dbg_state_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  localparam logic [SHAMT_W-1:0] EIGHT = SHAMT_W'(8);
  localparam logic [SHAMT_W-1:0] TWO   = SHAMT_W'(2);
  localparam logic [SHAMT_W-1:0] ONE   = SHAMT_W'(1);

  logic [SHAMT_W-1:0] rem_q;
  logic [1:0]         kind_q;
  logic               out_valid_q;
  logic [5:0]         ALUctrl_q;
  logic               out_first_q;
  logic               out_last_q;

  logic               accept;
  logic               is_shift;
  logic [1:0]         new_kind;
  logic [SHAMT_W-1:0] src_rem;
  logic [1:0]         src_kind;
  logic [SHAMT_W-1:0] step_sz;
  logic [5:0]         step_code;
  logic [5:0]         base_code;

  // Non-shift decode of ALUop and funct.
  function automatic logic [5:0] decode_ctrl(input logic [4:0] op, input logic [5:0] fn);
    logic [5:0] c;
    c = 6'h00;
    case (op)
      5'd0: c = 6'h02;
      5'd1: c = 6'h06;
      5'd2: begin
        case (fn)
          6'h10, 6'h12: c = 6'h00;
          6'h19:        c = 6'h13;
          6'h20:        c = 6'h02;
          6'h21:        c = 6'h03;
          6'h23:        c = 6'h06;
          6'h24:        c = 6'h00;
          6'h25:        c = 6'h01;
          6'h26:        c = 6'h04;
          6'h2A:        c = 6'h07;
          6'h2B:        c = 6'h08;
`ifdef ALUSEQ_CUSTOM_EN
          6'h30:        c = 6'h30;
          6'h34:        c = 6'h34;
`endif
          default:      c = 6'h00;
        endcase
      end
      5'd3: c = 6'h03;
      5'd4: c = 6'h00;
      5'd5: c = 6'h01;
      5'd6: c = 6'h04;
      5'd7: c = 6'h07;
      5'd8: c = 6'h08;
      5'd9: c = 6'h09;
      default: c = 6'h00;
    endcase
    return c;
  endfunction

  assign bus.in_ready  = (rem_q == '0);
  assign bus.out_valid = out_valid_q;
  assign bus.ALUctrl   = ALUctrl_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign dbg_state_o   = (rem_q == '0) ? IDLE : SEQ;

  always_comb begin
    accept   = bus.in_valid && bus.in_ready && !bus.flush;
    is_shift = (bus.ALUop == 5'd2) &&
               ((bus.functionCode == 6'h00) || (bus.functionCode == 6'h02) ||
                (bus.functionCode == 6'h03));
    case (bus.functionCode)
      6'h02:   new_kind = K_SRL;
      6'h03:   new_kind = K_SRA;
      default: new_kind = K_SLL;
    endcase

    // The first pass is computed straight from Shamt so it can be
    // registered in the same edge that accepts the request.
    src_rem  = accept ? bus.Shamt : rem_q;
    src_kind = accept ? new_kind  : kind_q;

    case (src_kind)
      K_SRL:   base_code = 6'h0F;
      K_SRA:   base_code = 6'h12;
      default: base_code = 6'h0C;
    endcase

    // Greedy: largest pass that does not overshoot the remaining count.
    // Within each kind the codes run 8-bit, 2-bit, 1-bit downward.
    if (src_rem >= EIGHT) begin
      step_sz   = EIGHT;
      step_code = base_code;
    end else if (src_rem >= TWO) begin
      step_sz   = TWO;
      step_code = base_code - 6'd1;
    end else begin
      step_sz   = ONE;
      step_code = base_code - 6'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q       <= '0;
      kind_q      <= K_SLL;
      out_valid_q <= 1'b0;
      ALUctrl_q   <= 6'h00;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (bus.flush) begin
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      ALUctrl_q   <= 6'h00;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_first_q <= 1'b1;
      if (is_shift && (bus.Shamt != '0)) begin
        kind_q     <= new_kind;
        ALUctrl_q  <= step_code;
        rem_q      <= bus.Shamt - step_sz;
        out_last_q <= (bus.Shamt == step_sz);
      end else begin
        // Non-shift ops and zero-amount shifts finish in one step;
        // a zero shift falls through the decode to 0x00.
        ALUctrl_q  <= decode_ctrl(bus.ALUop, bus.functionCode);
        rem_q      <= '0;
        out_last_q <= 1'b1;
      end
    end else if (rem_q != '0) begin
      out_valid_q <= 1'b1;
      out_first_q <= 1'b0;
      ALUctrl_q   <= step_code;
      rem_q       <= rem_q - step_sz;
      out_last_q  <= (rem_q == step_sz);
    end else begin
      out_valid_q <= 1'b0;
      ALUctrl_q   <= 6'h00;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
module tb_alu_shift_seq;

  logic       clk;
  logic       rst;
  logic [0:0] dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // Expected steps, each packed as {first, last, ALUctrl}.
  logic [7:0] exp_q[$];

  alu_shift_seq_if #(.SHAMT_W(5)) bus ();

  alu_shift_seq #(.SHAMT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [5:0] ref_decode(input logic [4:0] op, input logic [5:0] fn);
    if (op == 5'd2) begin
      case (fn)
        6'h19: return 6'h13;
        6'h20: return 6'h02;
        6'h21: return 6'h03;
        6'h23: return 6'h06;
        6'h25: return 6'h01;
        6'h26: return 6'h04;
        6'h2A: return 6'h07;
        6'h2B: return 6'h08;
`ifdef ALUSEQ_CUSTOM_EN
        6'h30: return 6'h30;
        6'h34: return 6'h34;
`endif
        default: return 6'h00;
      endcase
    end
    case (op)
      5'd0: return 6'h02;
      5'd1: return 6'h06;
      5'd3: return 6'h03;
      5'd5: return 6'h01;
      5'd6: return 6'h04;
      5'd7: return 6'h07;
      5'd8: return 6'h08;
      5'd9: return 6'h09;
      default: return 6'h00;
    endcase
  endfunction

  function automatic void model_push(input logic [4:0] op, input logic [5:0] fn,
                                     input logic [4:0] sh);
    logic [5:0] codes[$];
    logic [5:0] c8, c2, c1;
    int s;
    s = int'(sh);
    if (op == 5'd2 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) && s != 0) begin
      case (fn)
        6'h00:   begin c8 = 6'h0C; c2 = 6'h0B; c1 = 6'h0A; end
        6'h02:   begin c8 = 6'h0F; c2 = 6'h0E; c1 = 6'h0D; end
        default: begin c8 = 6'h12; c2 = 6'h11; c1 = 6'h10; end
      endcase
      repeat (s / 8)       codes.push_back(c8);
      repeat ((s % 8) / 2) codes.push_back(c2);
      repeat (s % 2)       codes.push_back(c1);
    end else begin
      codes.push_back(ref_decode(op, fn));
    end
    foreach (codes[i])
      exp_q.push_back({(i == 0), (i == codes.size() - 1), codes[i]});
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, " model_empty"}, 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, " out_valid"}, 8'(bus.out_valid), 8'd1);
      check({tag, " ALUctrl"},   8'(bus.ALUctrl),   8'(e[5:0]));
      check({tag, " out_first"}, 8'(bus.out_first), 8'(e[7]));
      check({tag, " out_last"},  8'(bus.out_last),  8'(e[6]));
      check({tag, " in_ready"},  8'(bus.in_ready),  8'(e[6]));
      check({tag, " state"},     8'(dbg_state),     8'(!e[6]));
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, " out_valid"}, 8'(bus.out_valid), 8'd0);
    check({tag, " ALUctrl"},   8'(bus.ALUctrl),   8'd0);
    check({tag, " out_first"}, 8'(bus.out_first), 8'd0);
    check({tag, " out_last"},  8'(bus.out_last),  8'd0);
    check({tag, " in_ready"},  8'(bus.in_ready),  8'd1);
  endtask

  // ---------------- driver ----------------
  task automatic set_req(input logic [4:0] op, input logic [5:0] fn, input logic [4:0] sh);
    bus.ALUop        = op;
    bus.functionCode = fn;
    bus.Shamt        = sh;
    bus.in_valid     = 1'b1;
  endtask

  // Presents one request while idle and checks every step it produces.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [5:0] fn,
                        input logic [4:0] sh);
    int n;
    @(negedge clk);
    set_req(op, fn, sh);
    model_push(op, fn, sh);
    n = exp_q.size();
    @(posedge clk);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_step(tag);
    end
    @(negedge clk);
    idle_check({tag, " after"});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] fn_r;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.ALUop    = '0;
    bus.functionCode = '0;
    bus.Shamt    = '0;
    #2 rst = 1'b0;
    #1 idle_check("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_check("post_reset");

    // SLL 11: 8,2,1 with a request held during the stall that must be ignored.
    @(negedge clk);
    set_req(5'd2, 6'h00, 5'd11);
    model_push(5'd2, 6'h00, 5'd11);
    @(posedge clk);
    @(negedge clk);
    set_req(5'd9, 6'h00, 5'd0);
    check_step("sll11 s1");
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_step("sll11 s2");
    @(negedge clk);
    check_step("sll11 s3");
    @(negedge clk);
    idle_check("sll11 after");

    // SRA 31 with an ADD presented on the last step (back-to-back).
    @(negedge clk);
    set_req(5'd2, 6'h03, 5'd31);
    model_push(5'd2, 6'h03, 5'd31);
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_step("sra31");
      if (k == 7) begin
        set_req(5'd2, 6'h20, 5'd0);
        model_push(5'd2, 6'h20, 5'd0);
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_step("b2b add");
    @(negedge clk);
    idle_check("b2b after");

    run_op("aluop9",    5'd9,  6'h00, 5'd0);
    run_op("funct19",   5'd2,  6'h19, 5'd0);
    run_op("sll0",      5'd2,  6'h00, 5'd0);
    run_op("srl1",      5'd2,  6'h02, 5'd1);
    run_op("sll8",      5'd2,  6'h00, 5'd8);
    run_op("aluop1",    5'd1,  6'h2A, 5'd3);
    run_op("slt",       5'd2,  6'h2A, 5'd0);
    run_op("custom30",  5'd2,  6'h30, 5'd0);
    run_op("custom34",  5'd2,  6'h34, 5'd0);
    run_op("aluop2unk", 5'd2,  6'h3F, 5'd7);
    run_op("aluop31",   5'd31, 6'h20, 5'd0);

    // SRL 9, reset asserted during step 1.
    @(negedge clk);
    set_req(5'd2, 6'h02, 5'd9);
    model_push(5'd2, 6'h02, 5'd9);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_step("srl9 s1");
    rst = 1'b0;
    #1 idle_check("srl9 in_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_check("srl9 released");
    @(negedge clk);
    idle_check("srl9 released2");

    // SLL 5, flush with a new request on step 1.
    @(negedge clk);
    set_req(5'd2, 6'h00, 5'd5);
    model_push(5'd2, 6'h00, 5'd5);
    @(posedge clk);
    @(negedge clk);
    check_step("sll5 s1");
    set_req(5'd9, 6'h00, 5'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    idle_check("flush next");
    exp_q.delete();
    @(negedge clk);
    idle_check("flush dropped");

    // Flush while idle only drops the request.
    @(negedge clk);
    set_req(5'd0, 6'h00, 5'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    idle_check("flush idle");

    // Randomized requests against the model.
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          case ($urandom_range(0, 2))
            0:       fn_r = 6'h00;
            1:       fn_r = 6'h02;
            default: fn_r = 6'h03;
          endcase
          run_op("rnd_shift", 5'd2, fn_r, 5'($urandom_range(0, 31)));
        end
        2:       run_op("rnd_rtype", 5'd2, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)));
        default: run_op("rnd_op", 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
                        5'($urandom_range(0, 31)));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
